// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
//
// Instruction fetch initiator for a combinational program ROM. Owns the
// program counter; the control unit only raises fetch requests and optional
// branch targets. Chip select is held for WAIT_CYCLES edges before the ROM
// output is sampled, so a high-impedance (deselected) bus never reaches the
// instruction register.
//
// Parameters
//   ADDR_WIDTH   ROM address width; PC wraps modulo 2^ADDR_WIDTH
//   DATA_WIDTH   ROM word width
//   WAIT_CYCLES  edges chip select is held before sampling (1..15)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   fetch_req    fetch the word at the current PC (honoured only in IDLE)
//   branch_en    load branch_addr as next PC (deferred if a fetch is running)
//   branch_addr  branch target
//   rom_address  ROM address pins (stable while rom_cs is high)
//   rom_cs       ROM chip select
//   rom_data     ROM data output
//   instr        instruction register
//   instr_valid  one-cycle pulse, instr updated at this edge
//   pc           current program counter
//   busy         fetch in progress
// ---------------------------------------------------------------------------
module rom_fetch_unit #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_cs,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // WAIT_CYCLES is limited to 15, so a 4-bit counter always suffices.
  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   rom_address_q, rom_address_d;
  logic                    rom_cs_q, rom_cs_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    instr_valid_q, instr_valid_d;
  logic                    done;

  // Last edge of the chip-select window: the ROM output has settled.
  assign done = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_req) state_d = ST_WAIT;
      ST_WAIT: if (done)      state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    pc_d          = pc_q;
    rom_address_d = rom_address_q;
    rom_cs_d      = rom_cs_q;
    busy_d        = busy_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (branch_en) begin
          pc_d = branch_addr;
        end
        if (fetch_req) begin
          // A branch in the same cycle redirects this very fetch.
          rom_address_d = branch_en ? branch_addr : pc_q;
          rom_cs_d      = 1'b1;
          busy_d        = 1'b1;
          cnt_d         = '0;
          pend_d        = 1'b0;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        // Branches arriving mid-fetch are parked; the latest one wins.
        if (branch_en) begin
          pend_d      = 1'b1;
          pend_addr_d = branch_addr;
        end
        if (done) begin
          instr_d       = rom_data;
          instr_valid_d = 1'b1;
          rom_cs_d      = 1'b0;
          busy_d        = 1'b0;
          cnt_d         = '0;
          pend_d        = 1'b0;
          // A branch on the completion edge itself is the newest target.
          if (branch_en) begin
            pc_d = branch_addr;
          end else if (pend_q) begin
            pc_d = pend_addr_q;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end

      default: begin
        rom_cs_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers; reset aborts any fetch in progress, dropping rom_cs
  // without waiting for a clock edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
      pc_q          <= '0;
      rom_address_q <= '0;
      rom_cs_q      <= 1'b0;
      busy_q        <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
      pc_q          <= pc_d;
      rom_address_q <= rom_address_d;
      rom_cs_q      <= rom_cs_d;
      busy_q        <= busy_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign rom_address = rom_address_q;
  assign rom_cs      = rom_cs_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_unit
//
// Directed bench for rom_fetch_unit. Two instances share a ROM model:
// u1 with WAIT_CYCLES=1 and u3 with WAIT_CYCLES=3. The ROM returns a
// distinctive "floating" pattern whenever it is deselected.
// ---------------------------------------------------------------------------
module tb_rom_fetch_unit;

  localparam logic [31:0] FLOAT_PAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem [0:31];

  // u1 (WAIT_CYCLES = 1)
  logic        fr1, be1, cs1, val1, busy1;
  logic [4:0]  ba1, addr1, pc1;
  logic [31:0] data1, instr1;
  // u3 (WAIT_CYCLES = 3)
  logic        fr3, be3, cs3, val3, busy3;
  logic [4:0]  ba3, addr3, pc3;
  logic [31:0] data3, instr3;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign data1 = cs1 ? mem[addr1] : FLOAT_PAT;
  assign data3 = cs3 ? mem[addr3] : FLOAT_PAT;

  rom_fetch_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .fetch_req(fr1), .branch_en(be1),
    .branch_addr(ba1), .rom_address(addr1), .rom_cs(cs1), .rom_data(data1),
    .instr(instr1), .instr_valid(val1), .pc(pc1), .busy(busy1)
  );

  rom_fetch_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .fetch_req(fr3), .branch_en(be3),
    .branch_addr(ba3), .rom_address(addr3), .rom_cs(cs3), .rom_data(data3),
    .instr(instr3), .instr_valid(val3), .pc(pc3), .busy(busy3)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Step past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int last_val;
    int nval;
    int exp_i;
    logic [31:0] addr_hold;

    reset = 1'b1;
    fr1 = 0; be1 = 0; ba1 = '0;
    fr3 = 0; be3 = 0; ba3 = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    mem[0] = 32'h0000_0010;
    tick();
    tick();
    reset = 1'b0;

    // ---------------- reset values ----------------
    check_value("rst_pc",    32'(pc1),    32'd0);
    check_value("rst_addr",  32'(addr1),  32'd0);
    check_value("rst_cs",    32'(cs1),    32'd0);
    check_value("rst_instr", instr1,      32'd0);
    check_value("rst_valid", 32'(val1),   32'd0);
    check_value("rst_busy",  32'(busy1),  32'd0);

    // ---------------- single fetch, WAIT_CYCLES=1 ----------------
    fr1 = 1'b1;
    tick();
    fr1 = 1'b0;
    check_value("f1_cs_high",   32'(cs1),   32'd1);
    check_value("f1_busy_high", 32'(busy1), 32'd1);
    check_value("f1_addr",      32'(addr1), 32'd0);
    tick();
    check_value("f1_instr",  instr1,     32'h0000_0010);
    check_value("f1_valid",  32'(val1),  32'd1);
    check_value("f1_pc",     32'(pc1),   32'd1);
    check_value("f1_cs_low", 32'(cs1),   32'd0);
    check_value("f1_busy_low", 32'(busy1), 32'd0);
    tick();
    check_value("f1_valid_pulse", 32'(val1), 32'd0);

    // ---------------- continuous fetch with PC wrap ----------------
    mem[0] = 32'd0;
    pulse_reset();
    fr1 = 1'b1;
    last_val = 0;
    nval = 0;
    for (int t = 1; t <= 66; t++) begin
      tick();
      if (cs1 !== busy1) check_value($sformatf("cont_cs_busy_t%0d", t), 32'(cs1), 32'(busy1));
      if (val1) begin
        exp_i = nval % 32;
        check_value($sformatf("cont_instr_%0d", nval), instr1, 32'(exp_i));
        check_value($sformatf("cont_cs_idle_%0d", nval), 32'(cs1), 32'd0);
        check_value($sformatf("cont_gap_%0d", nval), 32'(t - last_val), 32'd2);
        last_val = t;
        nval++;
      end
    end
    fr1 = 1'b0;
    check_value("cont_count", 32'(nval), 32'd33);
    check_value("cont_pc_wrap", 32'(pc1), 32'd1);

    // ---------------- branch cases on u1 ----------------
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
    be1 = 1'b1; ba1 = 5'd2;
    tick();
    be1 = 1'b0;
    check_value("br_idle_pc", 32'(pc1), 32'd2);
    fr1 = 1'b1; be1 = 1'b1; ba1 = 5'd5;
    tick();
    fr1 = 1'b0; be1 = 1'b0; ba1 = 5'd0;
    check_value("br_same_addr", 32'(addr1), 32'd5);
    tick();
    check_value("br_same_instr", instr1, 32'hA000_0005);
    check_value("br_same_pc", 32'(pc1), 32'd6);

    be1 = 1'b1; ba1 = 5'd3;
    tick();
    be1 = 1'b0;
    fr1 = 1'b1;
    tick();
    fr1 = 1'b0; be1 = 1'b1; ba1 = 5'd9;
    tick();
    be1 = 1'b0;
    check_value("br_wait1_instr", instr1, 32'hA000_0003);
    check_value("br_wait1_pc", 32'(pc1), 32'd9);

    // ---------------- WAIT_CYCLES=3 window ----------------
    pulse_reset();
    fr3 = 1'b1;
    tick();                                    // edge N
    fr3 = 1'b0;
    check_value("w3_cs_e0", 32'(cs3), 32'd1);
    addr_hold = 32'(addr3);
    check_value("w3_addr_e0", addr_hold, 32'd0);
    fr3 = 1'b1;                                // ignored: already in WAIT
    tick();                                    // edge N+1
    fr3 = 1'b0;
    check_value("w3_cs_e1",   32'(cs3),   32'd1);
    check_value("w3_busy_e1", 32'(busy3), 32'd1);
    check_value("w3_val_e1",  32'(val3),  32'd0);
    check_value("w3_addr_e1", 32'(addr3), addr_hold);
    tick();                                    // edge N+2
    check_value("w3_cs_e2",   32'(cs3),   32'd1);
    check_value("w3_val_e2",  32'(val3),  32'd0);
    check_value("w3_addr_e2", 32'(addr3), addr_hold);
    tick();                                    // edge N+3: capture
    check_value("w3_val_e3",   32'(val3),  32'd1);
    check_value("w3_busy_e3",  32'(busy3), 32'd0);
    check_value("w3_cs_e3",    32'(cs3),   32'd0);
    check_value("w3_instr_e3", instr3,     32'hA000_0000);
    check_value("w3_pc_e3",    32'(pc3),   32'd1);
    nval = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (val3) nval++;
      if (cs3) nval++;
    end
    check_value("w3_no_queued_fetch", 32'(nval), 32'd0);

    // ---------------- branch during WAIT on u3 (latest wins) ----------------
    be3 = 1'b1; ba3 = 5'd3;
    tick();
    be3 = 1'b0;
    fr3 = 1'b1;
    tick();                                    // fetch at pc=3
    fr3 = 1'b0; be3 = 1'b1; ba3 = 5'd7;
    tick();
    ba3 = 5'd9;
    tick();
    be3 = 1'b0; ba3 = 5'd0;
    check_value("br_wait3_pc_held", 32'(pc3), 32'd3);
    tick();
    check_value("br_wait3_valid", 32'(val3), 32'd1);
    check_value("br_wait3_instr", instr3,    32'hA000_0003);
    check_value("br_wait3_pc",    32'(pc3),  32'd9);
    tick();

    // ---------------- reset mid-WAIT ----------------
    fr3 = 1'b1;
    tick();                                    // fetch at pc=9
    fr3 = 1'b0;
    tick();                                    // second WAIT cycle
    #2 reset = 1'b1;
    #1;
    check_value("mr_cs_async", 32'(cs3),  32'd0);
    check_value("mr_pc",       32'(pc3),  32'd0);
    check_value("mr_instr",    instr3,    32'd0);
    check_value("mr_busy",     32'(busy3), 32'd0);
    tick();
    reset = 1'b0;
    nval = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (val3) nval++;
    end
    check_value("mr_no_valid", 32'(nval), 32'd0);
    fr3 = 1'b1;
    tick();
    fr3 = 1'b0;
    check_value("mr_refetch_addr", 32'(addr3), 32'd0);
    tick();
    tick();
    tick();
    check_value("mr_refetch_valid", 32'(val3), 32'd1);
    check_value("mr_refetch_instr", instr3,    32'hA000_0000);
    check_value("mr_float_never", 32'(instr3 == FLOAT_PAT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    tests_run++;
    tests_failed++;
    $display("FAIL timeout: got stuck expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
# rom_fetch_unit

Instruction fetch initiator that drives the program ROM's `address`/`chip_select` pins and captures its 32-bit `data_out` into an instruction register. It owns the program counter, so the control unit only issues fetch requests and optional branch targets. The block sits between the control unit and the 32-word program ROM. It holds chip select for a programmable number of cycles before sampling, because the ROM output is combinational and floats high-impedance while deselected.

## Interface
Parameters:
- ADDR_WIDTH, 5, ROM address width; the PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, ROM word width.
- WAIT_CYCLES, 1, clock edges chip select is held before `rom_data` is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  control unit requests the word at the current PC; sampled only in IDLE.
- branch_en  in  1  load `branch_addr` as the next PC.
- branch_addr  in  ADDR_WIDTH  branch target.
- rom_address  out  ADDR_WIDTH  to ROM `address`.
- rom_cs  out  1  to ROM `chip_select`.
- rom_data  in  DATA_WIDTH  from ROM `data_out` (Z when deselected).
- instr  out  DATA_WIDTH  instruction register; holds its value until the next capture.
- instr_valid  out  1  one-cycle pulse; `instr` was updated at this edge.
- pc  out  ADDR_WIDTH  current program counter.
- busy  out  1  high while a fetch is in progress.

## Operation
- States: IDLE, WAIT. All outputs are registered.
- IDLE:
  - `rom_cs`=0 and `busy`=0.
  - If `branch_en`=1, then `pc`<=`branch_addr`.
  - If `fetch_req`=1, then `rom_address`<=(`branch_en` ? `branch_addr` : `pc`), `rom_cs`<=1, `busy`<=1, `cnt`<=0, and the state goes to WAIT. The same-cycle branch wins, so the fetch uses the new target.
- WAIT:
  - `cnt` increments each edge.
  - When `cnt`==WAIT_CYCLES-1:
    - `instr`<=`rom_data`, `instr_valid`<=1, `rom_cs`<=0, `busy`<=0, state<=IDLE.
    - `pc`<=pending branch if one is held, else `pc`+1 (mod 2^ADDR_WIDTH; 31 wraps to 0).
- Branch during WAIT: `branch_addr` is latched into a pending register and the pending flag is set. It is applied at completion in place of the increment. A later `branch_en` in the same WAIT overwrites the earlier one. The flag is cleared at completion.
- `fetch_req` is ignored in WAIT; no request queueing.
- `rom_address` is stable for the whole time `rom_cs`=1 and keeps its last value after deselect.
- `rom_data` is never sampled while `rom_cs`=0, so Z never reaches `instr`.

## Timing
- Reset values: `pc`=0, `rom_address`=0, `rom_cs`=0, `instr`=0, `instr_valid`=0, `busy`=0, state=IDLE, `cnt`=0, pending flag=0.
- Reset mid-fetch aborts immediately:
  - `rom_cs` drops asynchronously.
  - No `instr_valid` pulse is generated.
  - `pc` returns to 0.
- Fetch sequence:
  - `fetch_req` is sampled at edge N.
  - `rom_cs`=1 from edge N to edge N+WAIT_CYCLES.
  - `rom_data` is captured at edge N+WAIT_CYCLES.
  - `instr_valid`=1 for exactly the cycle after edge N+WAIT_CYCLES.
- Latency: WAIT_CYCLES edges from request to capture.
- Throughput: with `fetch_req` held high, at most one fetch per WAIT_CYCLES+1 cycles, since one IDLE cycle is needed between fetches.
- `pc` updates at the same edge that `instr_valid` rises.

## Test plan
- Reset then single fetch, WAIT_CYCLES=1, ROM[0]=32'h0000_0010:
  - `fetch_req` sampled at edge 1.
  - `rom_cs`=1 for one cycle.
  - `instr`=32'h0000_0010 and `instr_valid`=1 after edge 2; `pc`=1.
- Continuous `fetch_req` for 64 cycles, ROM[i]=i:
  - `instr` sequence is 0..31, then 0 again (PC wrap).
  - `instr_valid` pulses every 2 cycles.
  - `rom_cs` is never high in IDLE.
- WAIT_CYCLES=3:
  - `rom_cs` stays high exactly 3 cycles.
  - `rom_address` is stable throughout.
  - Capture occurs at the 3rd edge; `busy` is deasserted with `instr_valid`.
- Branch cases:
  - `branch_en` with `branch_addr`=5 in the same cycle as `fetch_req` at `pc`=2: fetch reads ROM[5], and `pc`=6 afterward.
  - `branch_en` with `branch_addr`=9 during WAIT of a fetch at `pc`=3: `instr`=ROM[3], then `pc`=9.
- `reset` asserted mid-WAIT (WAIT_CYCLES=3, 2nd cycle):
  - `rom_cs`=0 immediately and no `instr_valid` pulse.
  - `pc`=0 and `instr`=0.
  - The next fetch reads ROM[0].
- `fetch_req` pulsed during WAIT: ignored; exactly one `instr_valid` per accepted request.
